led_fader: RTL and testbench

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 130 +++++++++++++
 tb/tb_led_fader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// led_fader: per-channel LED brightness fader with frame-aligned PWM drive.
// Build macro LED_FADER_GAMMA_EN selects a squared (gamma) level-to-duty mapping.
module led_fader #(
    parameter int NCH      = 5,
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 4096
) (
    input  logic           clki,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic           hold,
    output logic [NCH-1:0] led,
    output logic           busy
);

    // state        | meaning
    // CH_OFF       | req=0, level at 0
    // CH_RAMP_UP   | req=1, level below MAX, climbs one count per step_tick
    // CH_ON        | req=1, level at MAX
    // CH_RAMP_DOWN | req=0, level above 0, falls one count per step_tick
    typedef enum logic [1:0] {
        CH_OFF,
        CH_RAMP_UP,
        CH_ON,
        CH_RAMP_DOWN
    } ch_state_e;

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX        = '1;
    localparam logic [PWM_BITS-1:0] LVL_ONE    = PWM_BITS'(1);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0]       PRESC_ONE  = PW'(1);

    logic [PWM_BITS-1:0]          pwm_cnt_q, pwm_cnt_d;
    logic [PW-1:0]                presc_q, presc_d;
    logic [NCH-1:0][PWM_BITS-1:0] lvl_q, lvl_d;
    logic [NCH-1:0][PWM_BITS-1:0] duty_q, duty_d;
    logic [NCH-1:0]               led_q, led_d;
    logic                         busy_q, busy_d;

    logic                         step_tick;
    logic                         frame_end;
    ch_state_e                    ch_state [NCH];

    function automatic logic [PWM_BITS-1:0] lvl_to_duty(input logic [PWM_BITS-1:0] l);
`ifdef LED_FADER_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, l} * {{PWM_BITS{1'b0}}, l};
        sq = sq >> PWM_BITS;
        // Squaring alone tops out below MAX; full level must still mean solid on.
        if (l == MAX) begin
            return MAX;
        end
        return sq[PWM_BITS-1:0];
`else
        return l;
`endif
    endfunction

    assign step_tick = !hold && (presc_q == PRESC_LAST);
    assign frame_end = (pwm_cnt_q == MAX);

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + LVL_ONE;

        presc_d = presc_q;
        if (!hold) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_ONE;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            if (req[i]) begin
                ch_state[i] = (lvl_q[i] == MAX) ? CH_ON : CH_RAMP_UP;
            end else begin
                ch_state[i] = (lvl_q[i] == '0) ? CH_OFF : CH_RAMP_DOWN;
            end
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < NCH; i++) begin
            case (ch_state[i])
                CH_RAMP_UP:   if (step_tick) lvl_d[i] = lvl_q[i] + LVL_ONE;
                CH_RAMP_DOWN: if (step_tick) lvl_d[i] = lvl_q[i] - LVL_ONE;
                default:      lvl_d[i] = lvl_q[i];
            endcase
        end
    end

    // Duty only reloads on the last count of a frame, so each frame is whole.
    always_comb begin
        duty_d = duty_q;
        led_d  = '0;
        busy_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (frame_end) begin
                duty_d[i] = lvl_to_duty(lvl_q[i]);
            end
            led_d[i] = (duty_q[i] == MAX) || (pwm_cnt_q < duty_q[i]);
            if (lvl_q[i] != (req[i] ? MAX : '0)) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            lvl_q     <= '0;
            duty_q    <= '0;
            led_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
            lvl_q     <= lvl_d;
            duty_q    <= duty_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed checks of led_fader at NCH=5, PWM_BITS=4, STEP_DIV=2.
// Expected values follow the LED_FADER_GAMMA_EN setting of the build.
module tb_led_fader;

    localparam int NCH = 5;

`ifdef LED_FADER_GAMMA_EN
    localparam int DUTY_L5 = 1;
    localparam int DUTY_L7 = 3;
    localparam int LED2_AT_K20 = 0;
`else
    localparam int DUTY_L5 = 5;
    localparam int DUTY_L7 = 7;
    localparam int LED2_AT_K20 = 1;
`endif

    logic           clki = 1'b0;
    logic           rst  = 1'b0;
    logic [NCH-1:0] req  = '0;
    logic           hold = 1'b0;
    logic [NCH-1:0] led;
    logic           busy;

    int n_chk  = 0;
    int n_pass = 0;

    int rec_led0 [0:64];
    int rec_busy [0:64];
    int rec_lvl0 [0:64];

    led_fader #(.NCH(NCH), .PWM_BITS(4), .STEP_DIV(2)) dut (
        .clki  (clki),
        .reset (rst),
        .req   (req),
        .hold  (hold),
        .led   (led),
        .busy  (busy)
    );

    always #5 clki = ~clki;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clki);
    endtask

    // Holds reset for 3 cycles, then releases it on a falling edge with req applied.
    task automatic do_reset(input logic [NCH-1:0] r);
        int bad;
        bad = 0;
        rst  = 1'b1;
        req  = '0;
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clki);
            if (led !== '0 || busy !== 1'b0) bad++;
        end
        chk("reset_outputs", 32'(bad), 32'd0);
        rst = 1'b0;
        req = r;
    endtask

    task automatic count_led(input int bit_i, input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clki);
            if (led[bit_i]) highs++;
        end
    endtask

    initial begin
        int bad;
        int highs;

        #2 rst = 1'b1;

        // Idle: nothing requested, outputs stay quiet.
        do_reset('0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clki);
            if (led !== '0 || busy !== 1'b0) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        // Full ramp on channel 0, recorded per cycle k after reset release.
        do_reset(5'b00001);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clki);
            rec_led0[k] = int'(led[0]);
            rec_busy[k] = int'(busy);
            rec_lvl0[k] = int'(dut.lvl_q[0]);
        end
        chk("busy_after_req", 32'(rec_busy[1]), 32'd1);
        chk("lvl_k29", 32'(rec_lvl0[29]), 32'd14);
        chk("lvl_k30", 32'(rec_lvl0[30]), 32'd15);
        chk("busy_k30", 32'(rec_busy[30]), 32'd1);
        chk("busy_k31", 32'(rec_busy[31]), 32'd0);
        chk("lvl_saturated", 32'(rec_lvl0[64]), 32'd15);
        highs = 0;
        for (int k = 1; k <= 16; k++) highs += rec_led0[k];
        chk("frame0_highs", 32'(highs), 32'd0);
        highs = 0;
        for (int k = 17; k <= 32; k++) highs += rec_led0[k];
        chk("frame1_highs", 32'(highs), 32'(DUTY_L7));
        chk("frame1_first", 32'(rec_led0[17]), 32'd1);
        chk("frame1_last_high", 32'(rec_led0[16 + DUTY_L7]), 32'd1);
        chk("frame1_first_low", 32'(rec_led0[17 + DUTY_L7]), 32'd0);
        highs = 0;
        for (int k = 33; k <= 64; k++) highs += rec_led0[k];
        chk("full_on_highs", 32'(highs), 32'd32);

        // Hold at level 5: duty frozen, prescaler resumes where it stopped.
        do_reset(5'b00001);
        cyc(10);
        chk("lvl_before_hold", 32'(dut.lvl_q[0]), 32'd5);
        hold = 1'b1;
        cyc(21);
        count_led(0, 32, highs);
        chk("hold_duty", 32'(highs), 32'(2 * DUTY_L5));
        chk("hold_busy", 32'(busy), 32'd1);
        hold = 1'b0;
        cyc(1);
        chk("resume_no_step", 32'(dut.lvl_q[0]), 32'd5);
        cyc(1);
        chk("resume_step", 32'(dut.lvl_q[0]), 32'd6);

        // Reverse at level 8 and fade to off.
        do_reset(5'b00001);
        cyc(16);
        chk("lvl_at_reverse", 32'(dut.lvl_q[0]), 32'd8);
        req = 5'b00000;
        cyc(2);
        chk("down_first", 32'(dut.lvl_q[0]), 32'd7);
        cyc(14);
        chk("down_zero", 32'(dut.lvl_q[0]), 32'd0);
        chk("down_busy_k32", 32'(busy), 32'd1);
        cyc(1);
        chk("down_busy_k33", 32'(busy), 32'd0);
        cyc(17);
        count_led(0, 32, highs);
        chk("off_highs", 32'(highs), 32'd0);
        chk("off_no_wrap", 32'(dut.lvl_q[0]), 32'd0);

        // Several channels at once, then a mixed direction change.
        do_reset(5'b11010);
        cyc(30);
        chk("multi_busy_k30", 32'(busy), 32'd1);
        cyc(1);
        chk("multi_busy_k31", 32'(busy), 32'd0);
        cyc(9);
        chk("multi_led", 32'(led), 32'(5'b11010));
        req = 5'b01011;
        cyc(1);
        chk("multi_busy_change", 32'(busy), 32'd1);

        // Asynchronous reset mid-ramp, then a fresh ramp from zero.
        do_reset(5'b00100);
        cyc(20);
        chk("pre_reset_lvl2", 32'(dut.lvl_q[2]), 32'd10);
        chk("pre_reset_led2", 32'(led[2]), 32'(LED2_AT_K20));
        #2 rst = 1'b1;
        #1;
        chk("async_led", 32'(led), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_lvl2", 32'(dut.lvl_q[2]), 32'd0);
        do_reset(5'b00100);
        cyc(1);
        chk("restart_k1", 32'(dut.lvl_q[2]), 32'd0);
        cyc(1);
        chk("restart_k2", 32'(dut.lvl_q[2]), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
